// File: rtl/cpu_exec_ctrl.sv
// rtl/cpu_exec_ctrl.sv - run/step/halt execution controller with breakpoint, loop halt and instruction counter
//
// Ports:
//   clk, rst            system clock, asynchronous active-high reset
//   tick_in             one-clk pacing pulse from the frequency divider
//   run_btn, step_btn   raw asynchronous buttons (rising edge = run toggle / single step)
//   cnt_clr             synchronous clear of instr_cnt
//   bp_en, bp_addr      PC breakpoint enable and address
//   pc, pc_next         current PC and the value PC takes on the next enable
//   cpu_en              one-clk strobe per executed instruction
//   state               00 HALT, 01 RUN, 10 STEP, 11 BRK
//   brk_bp, brk_loop    sticky stop causes, cleared on leaving BRK
//   step_done           pulse coincident with the cpu_en of a single step
//   instr_cnt           saturating count of cpu_en strobes
module cpu_exec_ctrl #(
    parameter int ADDR_W      = 8,
    parameter int CNT_W       = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              tick_in,
    input  logic              run_btn,
    input  logic              step_btn,
    input  logic              cnt_clr,
    input  logic              bp_en,
    input  logic [ADDR_W-1:0] bp_addr,
    input  logic [ADDR_W-1:0] pc,
    input  logic [ADDR_W-1:0] pc_next,
    output logic              cpu_en,
    output logic [1:0]        state,
    output logic              brk_bp,
    output logic              brk_loop,
    output logic              step_done,
    output logic [CNT_W-1:0]  instr_cnt
);

    typedef enum logic [1:0] {
        S_HALT = 2'b00,
        S_RUN  = 2'b01,
        S_STEP = 2'b10,
        S_BRK  = 2'b11
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t                 st;
    logic [SYNC_STAGES-1:0] run_sync;
    logic [SYNC_STAGES-1:0] step_sync;
    logic                   run_prev;
    logic                   step_prev;
    logic                   run_e;
    logic                   step_e;
    logic                   bp_skip;
    logic                   bp_hit;

    assign state  = st;
    assign bp_hit = bp_en && (pc == bp_addr) && !bp_skip;

    // Button synchronizers and edge detectors; the edge pulse is registered so
    // a button edge reaches the FSM SYNC_STAGES+1 clocks later.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            run_sync  <= '0;
            step_sync <= '0;
            run_prev  <= 1'b0;
            step_prev <= 1'b0;
            run_e     <= 1'b0;
            step_e    <= 1'b0;
        end else begin
            run_sync  <= {run_sync[SYNC_STAGES-2:0], run_btn};
            step_sync <= {step_sync[SYNC_STAGES-2:0], step_btn};
            run_prev  <= run_sync[SYNC_STAGES-1];
            step_prev <= step_sync[SYNC_STAGES-1];
            run_e     <= run_sync[SYNC_STAGES-1] & ~run_prev;
            step_e    <= step_sync[SYNC_STAGES-1] & ~step_prev;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st        <= S_HALT;
            cpu_en    <= 1'b0;
            step_done <= 1'b0;
            brk_bp    <= 1'b0;
            brk_loop  <= 1'b0;
            bp_skip   <= 1'b0;
            instr_cnt <= '0;
        end else begin
            cpu_en    <= 1'b0;
            step_done <= 1'b0;

            // cpu_en is the registered strobe, so the count trails it by one clk.
            if (cnt_clr) begin
                instr_cnt <= '0;
            end else if (cpu_en && instr_cnt != CNT_MAX) begin
                instr_cnt <= instr_cnt + CNT_ONE;
            end

            case (st)
                S_HALT: begin
                    if (run_e) begin
                        st <= S_RUN;
                    end else if (step_e) begin
                        st <= S_STEP;
                    end
                end
                S_RUN: begin
                    if (run_e) begin
                        st <= S_HALT;
                    end else if (cpu_en && pc_next == pc) begin
                        // The strobed instruction jumps to itself: it has run
                        // once, so stop before the next tick repeats it.
                        st       <= S_BRK;
                        brk_loop <= 1'b1;
                    end else if (tick_in) begin
                        if (bp_hit) begin
                            st     <= S_BRK;
                            brk_bp <= 1'b1;
                        end else begin
                            cpu_en  <= 1'b1;
                            bp_skip <= 1'b0;
                        end
                    end
                end
                S_STEP: begin
                    if (run_e) begin
                        st <= S_RUN;
                    end else if (tick_in) begin
                        cpu_en    <= 1'b1;
                        step_done <= 1'b1;
                        bp_skip   <= 1'b0;
                        st        <= S_HALT;
                    end
                end
                S_BRK: begin
                    if (run_e) begin
                        // Let the instruction at the breakpoint execute on resume.
                        st       <= S_RUN;
                        bp_skip  <= 1'b1;
                        brk_bp   <= 1'b0;
                        brk_loop <= 1'b0;
                    end else if (step_e) begin
                        st       <= S_STEP;
                        brk_bp   <= 1'b0;
                        brk_loop <= 1'b0;
                    end
                end
                default: st <= S_HALT;
            endcase
        end
    end

endmodule
